// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the imem read-port arbiter.
package imem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int N_REQ             = 2;
  localparam int ADDR_W            = 6;
  localparam int DEFAULT_MAX_BURST = 4;

endpackage

// File: rtl/imem_arb_if.sv
// Bundle of requester handshakes plus the imem read port seen by the arbiter.
interface imem_arb_if import imem_arb_pkg::*; #(
  parameter int N = 32
) ();

  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              gnt0;
  logic              rvalid0;
  logic [N-1:0]      rdata0;

  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              gnt1;
  logic              rvalid1;
  logic [N-1:0]      rdata1;

  logic [ADDR_W-1:0] imem_addr;
  logic [N-1:0]      imem_q;

  // Requesters and the imem model drive this side.
  modport master (
    output req0, addr0, req1, addr1, imem_q,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, imem_addr
  );

  // The arbiter sits on this side.
  modport slave (
    input  req0, addr0, req1, addr1, imem_q,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, imem_addr
  );

endinterface

// File: rtl/imem_arb_resp.sv
// Per-requester response register: captures imem data on a granted beat.
module imem_arb_resp #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         gnt,
  input  logic [N-1:0] d,
  output logic         rvalid,
  output logic [N-1:0] rdata
);

  // rvalid pulses one cycle after each grant; rdata holds between beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (gnt) begin
      rvalid <= 1'b1;
      rdata  <= d;
    end else begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing the imem read port between fetch (0) and debug (1).
//
//   state | meaning
//   IDLE  | no tenure open, nobody granted last cycle
//   OWN0  | requester 0 holds the port, cnt = beats in this tenure
//   OWN1  | requester 1 holds the port, cnt = beats in this tenure
module imem_arbiter import imem_arb_pkg::*; #(
  parameter int N         = 32,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic     clk,
  input  logic     reset,
  imem_arb_if.slave bus
);

  localparam int                CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(MAX_BURST);

  arb_state_t        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              last, last_n;
  logic [N_REQ-1:0]  req;
  logic [N_REQ-1:0]  sel;
  logic [N_REQ-1:0]  gnt;
  logic [N_REQ-1:0]  rvalid;
  logic [N-1:0]      rdata [N_REQ];
  logic              hit, who, own, oth;

  assign req = {bus.req1, bus.req0};

  // State, tenure counter and last-served register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      last  <= last_n;
    end
  end

  // Grant decision and next tenure; the owner keeps the port until its burst
  // is used up or it stops asking, so a waiter sees at most MAX_BURST beats.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    last_n  = last;
    hit     = 1'b0;
    who     = 1'b0;
    own     = (state == OWN1);
    oth     = ~own;
    case (state)
      IDLE: begin
        if (|req) begin
          hit     = 1'b1;
          who     = (req[0] && req[1]) ? ~last : req[1];
          state_n = who ? OWN1 : OWN0;
          cnt_n   = CNT_W'(1);
          last_n  = who;
        end
      end
      OWN0, OWN1: begin
        if (req[own] && (cnt < BURST_CNT)) begin
          hit   = 1'b1;
          who   = own;
          cnt_n = cnt + 1'b1;
        end else if (req[oth]) begin
          hit     = 1'b1;
          who     = oth;
          state_n = oth ? OWN1 : OWN0;
          cnt_n   = CNT_W'(1);
          last_n  = oth;
        end else if (req[own]) begin
          hit   = 1'b1;
          who   = own;
          cnt_n = CNT_W'(1);
        end else begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    sel = hit ? (who ? 2'b10 : 2'b01) : 2'b00;
  end

  // Grants are suppressed during reset so no beat can land on a reset edge.
  always_comb begin
    gnt = reset ? '0 : sel;
    if (gnt[1])      bus.imem_addr = bus.addr1;
    else if (gnt[0]) bus.imem_addr = bus.addr0;
    else             bus.imem_addr = '0;
  end

  assign bus.gnt0 = gnt[0];
  assign bus.gnt1 = gnt[1];

  for (genvar i = 0; i < N_REQ; i++) begin : g_resp
    imem_arb_resp #(.N(N)) u_resp (
      .clk    (clk),
      .reset  (reset),
      .gnt    (gnt[i]),
      .d      (bus.imem_q),
      .rvalid (rvalid[i]),
      .rdata  (rdata[i])
    );
  end

  assign bus.rvalid0 = rvalid[0];
  assign bus.rvalid1 = rvalid[1];
  assign bus.rdata0  = rdata[0];
  assign bus.rdata1  = rdata[1];

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: grant table plus read-data scoreboard.
module tb_imem_arbiter;
  import imem_arb_pkg::*;

  typedef struct {
    logic       rst;
    logic       r0;
    logic [5:0] a0;
    logic       r1;
    logic [5:0] a1;
    logic       g0;
    logic       g1;
    logic [5:0] ia;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  int          checks = 0;
  int          errors = 0;
  vec_t        vecs[$];
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] e0, e1;

  imem_arb_if #(.N(32)) bus ();

  imem_arbiter #(.N(32), .MAX_BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [5:0] a);
    return 32'hA000_0000 | {26'd0, a};
  endfunction

  assign bus.imem_q = mem(bus.imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic r0, input logic [5:0] a0,
                     input logic r1, input logic [5:0] a1,
                     input logic g0, input logic g1, input logic [5:0] ia);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1;
    v.g0 = g0; v.g1 = g1; v.ia = ia;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, check the combinational grant mid-cycle.
  task automatic apply(input vec_t v, input string tag);
    reset     = v.rst;
    bus.req0  = v.r0;
    bus.addr0 = v.a0;
    bus.req1  = v.r1;
    bus.addr1 = v.a1;
    @(negedge clk);
    check({tag, " gnt0"}, {31'd0, bus.gnt0}, {31'd0, v.g0});
    check({tag, " gnt1"}, {31'd0, bus.gnt1}, {31'd0, v.g1});
    check({tag, " imem_addr"}, {26'd0, bus.imem_addr}, {26'd0, v.ia});
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic rst, input logic r0, input logic [5:0] a0,
                      input logic r1, input logic [5:0] a1,
                      input logic g0, input logic g1, input logic [5:0] ia,
                      input string tag);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1;
    v.g0 = g0; v.g1 = g1; v.ia = ia;
    apply(v, tag);
  endtask

  // Scoreboard: responses due this cycle are popped first, then new beats pushed.
  always @(negedge clk) begin
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      check("rvalid0", {31'd0, bus.rvalid0}, 32'd1);
      check("rdata0", bus.rdata0, e0);
    end else begin
      check("rvalid0 quiet", {31'd0, bus.rvalid0}, 32'd0);
    end
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      check("rvalid1", {31'd0, bus.rvalid1}, 32'd1);
      check("rdata1", bus.rdata1, e1);
    end else begin
      check("rvalid1 quiet", {31'd0, bus.rvalid1}, 32'd0);
    end
    if (bus.gnt0 && !reset) q0.push_back(mem(bus.addr0));
    if (bus.gnt1 && !reset) q1.push_back(mem(bus.addr1));
  end

  initial begin
    reset     = 1'b1;
    bus.req0  = 1'b1;
    bus.addr0 = 6'd7;
    bus.req1  = 1'b0;
    bus.addr1 = 6'd0;

    // Table: single beat, 4-beat alternation, solo streaming.
    add(0, 1, 6'd5, 0, 6'd0, 1, 0, 6'd5);
    add(0, 0, 6'd0, 0, 6'd0, 0, 0, 6'd0);
    add(1, 0, 6'd0, 0, 6'd0, 0, 0, 6'd0);
    for (int i = 0; i < 12; i++) begin
      if (i >= 4 && i < 8) add(0, 1, 6'd3, 1, 6'd9, 0, 1, 6'd9);
      else                 add(0, 1, 6'd3, 1, 6'd9, 1, 0, 6'd3);
    end
    add(0, 0, 6'd0, 0, 6'd0, 0, 0, 6'd0);
    for (int i = 0; i < 10; i++) add(0, 1, 6'(i), 0, 6'd0, 1, 0, 6'(i));
    add(0, 0, 6'd0, 0, 6'd0, 0, 0, 6'd0);

    @(posedge clk);
    #1;

    // Reset held with a pending request: nothing granted, outputs cleared.
    step(1, 1, 6'd7, 0, 6'd0, 0, 0, 6'd0, "rst0");
    step(1, 1, 6'd7, 0, 6'd0, 0, 0, 6'd0, "rst1");
    check("rst rvalid0", {31'd0, bus.rvalid0}, 32'd0);
    check("rst rvalid1", {31'd0, bus.rvalid1}, 32'd0);
    check("rst rdata0", bus.rdata0, 32'd0);
    check("rst rdata1", bus.rdata1, 32'd0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Owner 1 drops after two beats while 0 waits: switch with no dead cycle.
    step(0, 1, 6'd1, 1, 6'd33, 0, 1, 6'd33, "drop a");
    step(0, 1, 6'd1, 1, 6'd33, 0, 1, 6'd33, "drop b");
    step(0, 1, 6'd2, 0, 6'd0,  1, 0, 6'd2,  "drop c");
    check("drop state", 32'(dut.state), 32'(OWN0));
    check("drop cnt", 32'(dut.cnt), 32'd1);
    step(0, 0, 6'd0, 0, 6'd0, 0, 0, 6'd0, "drop idle");

    // Reset right after a grant to 1: that beat still returns, then all clears.
    step(0, 0, 6'd0,  1, 6'd40, 0, 1, 6'd40, "rg grant");
    step(1, 1, 6'd11, 1, 6'd40, 0, 0, 6'd0,  "rg reset");
    check("rg rvalid1", {31'd0, bus.rvalid1}, 32'd0);
    check("rg rdata1", bus.rdata1, 32'd0);
    check("rg state", 32'(dut.state), 32'(IDLE));
    step(0, 1, 6'd11, 1, 6'd40, 1, 0, 6'd11, "rg release");
    step(0, 0, 6'd0,  0, 6'd0,  0, 0, 6'd0,  "rg idle");
    @(negedge clk);
    check("pending0", 32'(q0.size()), 32'd0);
    check("pending1", 32'(q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single combinational read port of imem (6-bit word address, N-bit data) between two requesters: requester 0 = instruction fetch, requester 1 = debug/loader reader.
- Round-robin arbitration with a bounded burst tenure.
- Registers the imem data, so each accepted request returns its data exactly one cycle later.
- Sits between the fetch/debug logic and imem.

Parameters:
- N, 32, imem data width.
- MAX_BURST, 4, maximum consecutive beats one owner keeps while the other requester is waiting (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 read request.
- addr0  in  6  requester 0 word address.
- gnt0  out  1  requester 0 granted this cycle (combinational).
- rvalid0  out  1  rdata0 valid (registered).
- rdata0  out  N  requester 0 read data (registered).
- req1, addr1, gnt1, rvalid1, rdata1: same as requester 0, for requester 1.
- imem_addr  out  6  address driven to imem.addr.
- imem_q  in  N  data from imem.q (combinational in imem_addr).

Behaviour:
- Reset (sync, active-high) has priority over everything. It sets state=IDLE, cnt=0, last=1, rvalid0/1=0 and rdata0/1=0. gnt0/1 are forced to 0 while reset=1.
- Handshake:
  - A requester holds req and addr stable until it samples gnt=1 at a rising edge. A beat transfers on that edge.
  - At most one gnt is high per cycle.
  - A requester may keep req high for back-to-back beats, with a new addr each beat.
- Datapath:
  - imem_addr = addr of the granted requester; 0 when there is no grant.
  - On an edge with gntX=1: rdataX ← imem_q and rvalidX ← 1.
  - On an edge with gntX=0: rvalidX ← 0 and rdataX holds its value.
  - Latency is 1 cycle. Throughput is 1 beat/cycle in aggregate.
- FSM states: IDLE, OWN0, OWN1. cnt = beats granted in the current tenure, width $clog2(MAX_BURST+1). last = most recently served requester.
- IDLE:
  - Both requesting → grant !last.
  - One requesting → grant it.
  - None → stay IDLE.
  - On a grant: next state is OWNx, cnt=1, last=x.
- OWNx, evaluated in order:
  1. reqx && cnt<MAX_BURST → grant x, cnt++.
  2. Otherwise req_other → grant other, go to OWN_other, cnt=1, last=other.
  3. Otherwise reqx (burst exhausted, other idle) → grant x, cnt=1 (tenure restarts).
  4. Otherwise → no grant, go to IDLE, cnt=0.
- Bound: a waiting requester is granted within MAX_BURST cycles of raising req.
- Owner drops req mid-burst while the other requests → immediate switch; no dead cycle.
- Reset asserted on the same edge as a grant → the beat is discarded: rvalid=0 next cycle and no data captured.
- addr range 0..63 is always legal. The arbiter performs no range check; words at or above the image end read 0 from imem.

Decomposition:
- Package imem_arb_pkg:
  - typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t.
  - Localparams N_REQ=2, ADDR_W=6, DEFAULT_MAX_BURST=4.
- One natural sub-module: imem_arb_resp, the per-requester response register (rvalid/rdata capture), instantiated twice.
- Grant logic and the FSM remain in imem_arbiter.
- imem is instantiated by the parent, not inside the arbiter.

Test Plan:
Bench imem model drives imem_q = 32'hA000_0000 | imem_addr; MAX_BURST=4.
1. Reset held 2 cycles with req0=1, addr0=7 → gnt0=gnt1=0, rvalid0/1=0, rdata0/1=0, imem_addr=0.
2. After reset, req0=1, addr0=5 for one cycle → gnt0=1 and imem_addr=5 that cycle; next cycle rvalid0=1, rdata0=32'hA000_0005, rvalid1=0.
3. From IDLE, req0 and req1 both held, addr0=3, addr1=9 → gnt0 for 4 cycles, then gnt1 in cycle 5; one cycle later rvalid1=1, rdata1=32'hA000_0009. Owners then alternate in 4-beat tenures.
4. req0 alone for 10 cycles, addr0=0..9 → gnt0=1 every cycle, 10 consecutive rvalid0 pulses with rdata0=A000_0000..A000_0009, no bubbles.
5. Owner 1 drops req after 2 beats while req0=1 → gnt0=1 in the very next cycle, state OWN0, cnt=1.
6. reset asserted the cycle after a req1 grant → rvalid1=0 following the reset edge, state IDLE. On release with both requesting → gnt0 first (last=1).
